banked_dual_access_ram: RTL and testbench

Banked on-chip buffer with two independent access ports. Port A serves LD/ST traffic and port B serves RD/WR traffic, so both can proceed in the same cycle when they target different banks. The upper TAG_W address bits select one of NUM_TAGS banks; the lower bits address a word inside that bank. Each port returns read data one cycle after its request, through a registered bank-select tag feeding an N-to-1 output multiplexer.

---
 rtl/banked_dual_access_ram.sv | 115 +++++++++++
 tb/tb_banked_dual_access_ram.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/banked_dual_access_ram.sv
// Banked RAM with two independent ports (A: LD/ST, B: RD/WR); different banks proceed in parallel.
// Read data is valid one cycle after the request. There is no backpressure, and port A wins same-bank conflicts.
module banked_dual_access_ram #(
  parameter int  TAG_W        = 2,
  parameter int  DATA_WIDTH   = 16,
  parameter int  ADDR_WIDTH   = 13,
  localparam int NUM_TAGS     = 1 << TAG_W,
  localparam int LOCAL_ADDR_W = ADDR_WIDTH - TAG_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  s_read_req_a,
  input  logic [ADDR_WIDTH-1:0] s_read_addr_a,
  output logic [DATA_WIDTH-1:0] s_read_data_a,
  output logic                  s_read_valid_a,
  input  logic                  s_write_req_a,
  input  logic [ADDR_WIDTH-1:0] s_write_addr_a,
  input  logic [DATA_WIDTH-1:0] s_write_data_a,
  input  logic                  s_read_req_b,
  input  logic [ADDR_WIDTH-1:0] s_read_addr_b,
  output logic [DATA_WIDTH-1:0] s_read_data_b,
  output logic                  s_read_valid_b,
  input  logic                  s_write_req_b,
  input  logic [ADDR_WIDTH-1:0] s_write_addr_b,
  input  logic [DATA_WIDTH-1:0] s_write_data_b
);
  localparam int DEPTH = 1 << LOCAL_ADDR_W;

  logic [TAG_W-1:0]        rd_tag_a, rd_tag_b, wr_tag_a, wr_tag_b;
  logic [LOCAL_ADDR_W-1:0] rd_loc_a, rd_loc_b, wr_loc_a, wr_loc_b;

  assign rd_tag_a = s_read_addr_a[ADDR_WIDTH-1 -: TAG_W];
  assign rd_tag_b = s_read_addr_b[ADDR_WIDTH-1 -: TAG_W];
  assign wr_tag_a = s_write_addr_a[ADDR_WIDTH-1 -: TAG_W];
  assign wr_tag_b = s_write_addr_b[ADDR_WIDTH-1 -: TAG_W];
  assign rd_loc_a = s_read_addr_a[LOCAL_ADDR_W-1:0];
  assign rd_loc_b = s_read_addr_b[LOCAL_ADDR_W-1:0];
  assign wr_loc_a = s_write_addr_a[LOCAL_ADDR_W-1:0];
  assign wr_loc_b = s_write_addr_b[LOCAL_ADDR_W-1:0];

  logic [DATA_WIDTH-1:0]   mem        [NUM_TAGS][DEPTH];
  logic [NUM_TAGS-1:0]     bank_wen;
  logic [NUM_TAGS-1:0]     bank_ren;
  logic [LOCAL_ADDR_W-1:0] bank_waddr [NUM_TAGS];
  logic [DATA_WIDTH-1:0]   bank_wdata [NUM_TAGS];
  logic [LOCAL_ADDR_W-1:0] bank_raddr [NUM_TAGS];
  logic [DATA_WIDTH-1:0]   rdata_d    [NUM_TAGS];
  logic [DATA_WIDTH-1:0]   rdata_q    [NUM_TAGS];

  logic [TAG_W-1:0] rd_tag_a_dly_d, rd_tag_a_dly_q;
  logic [TAG_W-1:0] rd_tag_b_dly_d, rd_tag_b_dly_q;
  logic             rd_valid_a_d, rd_valid_a_q;
  logic             rd_valid_b_d, rd_valid_b_q;

  // Per-bank arbitration: port A has priority whenever both ports hit the same bank.
  always_comb begin
    for (int i = 0; i < NUM_TAGS; i++) begin
      bank_wen[i]   = 1'b0;
      bank_waddr[i] = wr_loc_b;
      bank_wdata[i] = s_write_data_b;
      bank_ren[i]   = 1'b0;
      bank_raddr[i] = rd_loc_b;
      if (s_write_req_a && (wr_tag_a == TAG_W'(i))) begin
        bank_wen[i]   = 1'b1;
        bank_waddr[i] = wr_loc_a;
        bank_wdata[i] = s_write_data_a;
      end else if (s_write_req_b && (wr_tag_b == TAG_W'(i))) begin
        bank_wen[i] = 1'b1;
      end
      if (s_read_req_a && (rd_tag_a == TAG_W'(i))) begin
        bank_ren[i]   = 1'b1;
        bank_raddr[i] = rd_loc_a;
      end else if (s_read_req_b && (rd_tag_b == TAG_W'(i))) begin
        bank_ren[i] = 1'b1;
      end
      rdata_d[i] = bank_ren[i] ? mem[i][bank_raddr[i]] : rdata_q[i];
    end
  end

  always_comb begin
    rd_tag_a_dly_d = s_read_req_a ? rd_tag_a : rd_tag_a_dly_q;
    rd_tag_b_dly_d = s_read_req_b ? rd_tag_b : rd_tag_b_dly_q;
    rd_valid_a_d   = s_read_req_a;
    rd_valid_b_d   = s_read_req_b;
  end

  // Storage is not reset; a read on the same edge as a write sees the old word.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_TAGS; i++) begin
      if (bank_wen[i]) mem[i][bank_waddr[i]] <= bank_wdata[i];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_tag_a_dly_q <= '0;
      rd_tag_b_dly_q <= '0;
      rd_valid_a_q   <= 1'b0;
      rd_valid_b_q   <= 1'b0;
      for (int i = 0; i < NUM_TAGS; i++) rdata_q[i] <= '0;
    end else begin
      rd_tag_a_dly_q <= rd_tag_a_dly_d;
      rd_tag_b_dly_q <= rd_tag_b_dly_d;
      rd_valid_a_q   <= rd_valid_a_d;
      rd_valid_b_q   <= rd_valid_b_d;
      rdata_q        <= rdata_d;
    end
  end

  assign s_read_data_a  = rdata_q[rd_tag_a_dly_q];
  assign s_read_data_b  = rdata_q[rd_tag_b_dly_q];
  assign s_read_valid_a = rd_valid_a_q;
  assign s_read_valid_b = rd_valid_b_q;

endmodule

// File: tb/tb_banked_dual_access_ram.sv
// Bench for banked_dual_access_ram: a reference memory model feeds per-port expected-data queues.
// Each scenario task drives stimulus and compares the DUT outputs inline.
module tb_banked_dual_access_ram;
  logic        clk;
  logic        reset;
  logic        s_read_req_a,  s_read_req_b;
  logic [12:0] s_read_addr_a, s_read_addr_b;
  logic [15:0] s_read_data_a, s_read_data_b;
  logic        s_read_valid_a, s_read_valid_b;
  logic        s_write_req_a, s_write_req_b;
  logic [12:0] s_write_addr_a, s_write_addr_b;
  logic [15:0] s_write_data_a, s_write_data_b;

  int total = 0;
  int bad   = 0;

  logic [15:0] model [int];
  logic [15:0] exp_a [$];
  logic [15:0] exp_b [$];

  banked_dual_access_ram dut (
    .clk            (clk),
    .reset          (reset),
    .s_read_req_a   (s_read_req_a),
    .s_read_addr_a  (s_read_addr_a),
    .s_read_data_a  (s_read_data_a),
    .s_read_valid_a (s_read_valid_a),
    .s_write_req_a  (s_write_req_a),
    .s_write_addr_a (s_write_addr_a),
    .s_write_data_a (s_write_data_a),
    .s_read_req_b   (s_read_req_b),
    .s_read_addr_b  (s_read_addr_b),
    .s_read_data_b  (s_read_data_b),
    .s_read_valid_b (s_read_valid_b),
    .s_write_req_b  (s_write_req_b),
    .s_write_addr_b (s_write_addr_b),
    .s_write_data_b (s_write_data_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drives one cycle from a negedge, pushes expected read data, updates the model, ends at the next negedge.
  task automatic cycle(input logic ra, input logic [12:0] aa, input logic rb, input logic [12:0] ab,
                       input logic wa, input logic [12:0] wa_ad, input logic [15:0] wa_d,
                       input logic wb, input logic [12:0] wb_ad, input logic [15:0] wb_d);
    s_read_req_a   = ra;  s_read_addr_a  = aa;
    s_read_req_b   = rb;  s_read_addr_b  = ab;
    s_write_req_a  = wa;  s_write_addr_a = wa_ad; s_write_data_a = wa_d;
    s_write_req_b  = wb;  s_write_addr_b = wb_ad; s_write_data_b = wb_d;
    if (ra) exp_a.push_back(model[int'(aa)]);
    if (rb) begin
      if (ra && (aa[12:11] == ab[12:11])) exp_b.push_back(model[int'(aa)]);
      else                                exp_b.push_back(model[int'(ab)]);
    end
    if (wa) model[int'(wa_ad)] = wa_d;
    if (wb && !(wa && (wa_ad[12:11] == wb_ad[12:11]))) model[int'(wb_ad)] = wb_d;
    @(posedge clk);
    @(negedge clk);
    s_read_req_a = 1'b0; s_read_req_b = 1'b0;
    s_write_req_a = 1'b0; s_write_req_b = 1'b0;
  endtask

  task automatic test_reset();
    #2 reset = 1'b0;
    #1;
    total++; if (s_read_data_a !== 16'h0) begin bad++; $display("FAIL reset_data_a: got %h want 0000", s_read_data_a); end
    total++; if (s_read_data_b !== 16'h0) begin bad++; $display("FAIL reset_data_b: got %h want 0000", s_read_data_b); end
    total++; if (s_read_valid_a !== 1'b0) begin bad++; $display("FAIL reset_valid_a: got %b want 0", s_read_valid_a); end
    total++; if (s_read_valid_b !== 1'b0) begin bad++; $display("FAIL reset_valid_b: got %b want 0", s_read_valid_b); end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    logic [15:0] e;
    cycle(0, 0, 0, 0, 1, 13'h0005, 16'h1234, 0, 0, 0);
    cycle(1, 13'h0005, 0, 0, 0, 0, 0, 0, 0, 0);
    e = exp_a.pop_front();
    total++; if (s_read_valid_a !== 1'b1) begin bad++; $display("FAIL basic_valid_a: got %b want 1", s_read_valid_a); end
    total++; if (s_read_data_a !== e) begin bad++; $display("FAIL basic_data_a: got %h want %h", s_read_data_a, e); end
  endtask

  task automatic test_hold();
    cycle(0, 0, 0, 0, 1, 13'h0005, 16'h9999, 0, 0, 0);
    total++; if (s_read_valid_a !== 1'b0) begin bad++; $display("FAIL hold_valid_a: got %b want 0", s_read_valid_a); end
    total++; if (s_read_data_a !== 16'h1234) begin bad++; $display("FAIL hold_data_a: got %h want 1234", s_read_data_a); end
  endtask

  task automatic test_parallel();
    logic [15:0] ea, eb;
    cycle(0, 0, 0, 0, 1, 13'h0010, 16'hAAAA, 1, 13'h0810, 16'hBBBB);
    cycle(1, 13'h0810, 1, 13'h0010, 0, 0, 0, 0, 0, 0);
    ea = exp_a.pop_front();
    eb = exp_b.pop_front();
    total++; if (s_read_data_a !== ea) begin bad++; $display("FAIL parallel_data_a: got %h want %h", s_read_data_a, ea); end
    total++; if (s_read_data_b !== eb) begin bad++; $display("FAIL parallel_data_b: got %h want %h", s_read_data_b, eb); end
    total++; if (s_read_valid_b !== 1'b1) begin bad++; $display("FAIL parallel_valid_b: got %b want 1", s_read_valid_b); end
  endtask

  task automatic test_write_conflict();
    logic [15:0] e;
    cycle(0, 0, 0, 0, 1, 13'h1003, 16'h1111, 1, 13'h1003, 16'h2222);
    cycle(0, 0, 1, 13'h1003, 0, 0, 0, 0, 0, 0);
    e = exp_b.pop_front();
    total++; if (s_read_data_b !== e) begin bad++; $display("FAIL wr_conflict_data_b: got %h want %h", s_read_data_b, e); end
  endtask

  task automatic test_read_conflict();
    logic [15:0] ea, eb;
    cycle(0, 0, 0, 0, 1, 13'h1804, 16'h5555, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 0, 1, 13'h1805, 16'h6666);
    cycle(1, 13'h1804, 1, 13'h1805, 0, 0, 0, 0, 0, 0);
    ea = exp_a.pop_front();
    eb = exp_b.pop_front();
    total++; if (s_read_data_a !== ea) begin bad++; $display("FAIL rd_conflict_data_a: got %h want %h", s_read_data_a, ea); end
    total++; if (s_read_data_b !== eb) begin bad++; $display("FAIL rd_conflict_data_b: got %h want %h", s_read_data_b, eb); end
  endtask

  task automatic test_read_during_write();
    logic [15:0] e;
    cycle(0, 0, 0, 0, 1, 13'h0020, 16'h0101, 0, 0, 0);
    cycle(1, 13'h0020, 0, 0, 0, 0, 0, 1, 13'h0020, 16'h0202);
    e = exp_a.pop_front();
    total++; if (s_read_data_a !== e) begin bad++; $display("FAIL rdw_old_data_a: got %h want %h", s_read_data_a, e); end
    cycle(1, 13'h0020, 0, 0, 0, 0, 0, 0, 0, 0);
    e = exp_a.pop_front();
    total++; if (s_read_data_a !== e) begin bad++; $display("FAIL rdw_new_data_a: got %h want %h", s_read_data_a, e); end
  endtask

  task automatic test_reset_mid();
    logic [15:0] ea, eb;
    cycle(1, 13'h0005, 1, 13'h0810, 0, 0, 0, 0, 0, 0);
    ea = exp_a.pop_front();
    eb = exp_b.pop_front();
    total++; if (s_read_data_a !== ea) begin bad++; $display("FAIL mid_pre_data_a: got %h want %h", s_read_data_a, ea); end
    total++; if (s_read_data_b !== eb) begin bad++; $display("FAIL mid_pre_data_b: got %h want %h", s_read_data_b, eb); end
    reset = 1'b0;
    #1;
    total++; if (s_read_data_a !== 16'h0) begin bad++; $display("FAIL mid_reset_data_a: got %h want 0000", s_read_data_a); end
    total++; if (s_read_data_b !== 16'h0) begin bad++; $display("FAIL mid_reset_data_b: got %h want 0000", s_read_data_b); end
    total++; if (s_read_valid_a !== 1'b0) begin bad++; $display("FAIL mid_reset_valid_a: got %b want 0", s_read_valid_a); end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [12:0] addrs [16];
    logic [15:0] e;
    logic        ra, rb, wa, wb;
    logic [12:0] aa, ab, wad, wbd;
    for (int i = 0; i < 16; i++) begin
      addrs[i] = 13'((i / 4) << 11) | 13'h0040 | 13'(i % 4);
      cycle(0, 0, 0, 0, 1, addrs[i], 16'($urandom), 0, 0, 0);
    end
    for (int n = 0; n < 80; n++) begin
      ra  = 1'($urandom_range(0, 1));
      rb  = 1'($urandom_range(0, 1));
      wa  = 1'($urandom_range(0, 1));
      wb  = 1'($urandom_range(0, 1));
      aa  = addrs[$urandom_range(0, 15)];
      ab  = addrs[$urandom_range(0, 15)];
      wad = addrs[$urandom_range(0, 15)];
      wbd = addrs[$urandom_range(0, 15)];
      cycle(ra, aa, rb, ab, wa, wad, 16'($urandom), wb, wbd, 16'($urandom));
      total++; if (s_read_valid_a !== ra) begin bad++; $display("FAIL b2b_valid_a[%0d]: got %b want %b", n, s_read_valid_a, ra); end
      total++; if (s_read_valid_b !== rb) begin bad++; $display("FAIL b2b_valid_b[%0d]: got %b want %b", n, s_read_valid_b, rb); end
      if (ra) begin
        e = exp_a.pop_front();
        total++; if (s_read_data_a !== e) begin bad++; $display("FAIL b2b_data_a[%0d]: got %h want %h", n, s_read_data_a, e); end
      end
      if (rb) begin
        e = exp_b.pop_front();
        total++; if (s_read_data_b !== e) begin bad++; $display("FAIL b2b_data_b[%0d]: got %h want %h", n, s_read_data_b, e); end
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    s_read_req_a = 1'b0;  s_read_addr_a = '0;
    s_read_req_b = 1'b0;  s_read_addr_b = '0;
    s_write_req_a = 1'b0; s_write_addr_a = '0; s_write_data_a = '0;
    s_write_req_b = 1'b0; s_write_addr_b = '0; s_write_data_b = '0;
    test_reset();
    test_basic();
    test_hold();
    test_parallel();
    test_write_conflict();
    test_read_conflict();
    test_read_during_write();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
